// File: rtl/spi_master_pkg.sv
// spi_master_pkg: shared types and default constants for the SPI master.
//   spi_state_e          - transfer FSM state encoding
//   SPI_DATA_WIDTH_DEF   - default bits per transfer
//   SPI_CLK_DIV_DEF      - default CLK cycles per SCLK half-period
package spi_master_pkg;

   typedef enum logic [1:0] {
      IDLE,
      SETUP,
      XFER,
      HOLD
   } spi_state_e;

   localparam int unsigned SPI_DATA_WIDTH_DEF = 8;
   localparam int unsigned SPI_CLK_DIV_DEF    = 4;

endpackage

// File: rtl/spi_clk_div.sv
// spi_clk_div: half-period tick generator for the SPI master.
//   clk_i  - system clock
//   rst_i  - synchronous active-high reset
//   en_i   - count enable; counter is held at 0 while low
//   tick_o - one-cycle pulse every CLK_DIV enabled cycles
module spi_clk_div
   import spi_master_pkg::*;
#(
   parameter int unsigned CLK_DIV = SPI_CLK_DIV_DEF
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic en_i,
   output logic tick_o
);

   localparam logic [7:0] LAST = 8'(CLK_DIV - 1);

   logic [7:0] cnt_q;

   assign tick_o = en_i && (cnt_q == LAST);

   always_ff @(posedge clk_i) begin
      if (rst_i || !en_i || tick_o) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_q + 8'd1;
      end
   end

endmodule

// File: rtl/spi_master.sv
// spi_master: mode-0 SPI master, MSB first, one word per transfer.
//   CLK, RST           - system clock, synchronous active-high reset
//   TX_DATA, TX_VALID  - word to send / start request (accepted when TX_READY)
//   TX_READY           - high only while idle
//   RX_DATA, RX_VALID  - received word, one-cycle valid pulse
//   SCLK, MOSI, MISO   - serial clock and data lines
//   CS                 - active-low chip select
//   ECHO_ERR           - only with SPI_MASTER_ECHO_CHECK_EN: pulses with
//                        RX_VALID when the received word differs from the sent one
module spi_master
   import spi_master_pkg::*;
#(
   parameter int unsigned CLK_DIV    = SPI_CLK_DIV_DEF,
   parameter int unsigned DATA_WIDTH = SPI_DATA_WIDTH_DEF
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic [DATA_WIDTH-1:0] TX_DATA,
   input  logic                  TX_VALID,
   output logic                  TX_READY,
   output logic [DATA_WIDTH-1:0] RX_DATA,
   output logic                  RX_VALID,
   output logic                  SCLK,
   output logic                  MOSI,
   input  logic                  MISO,
   output logic                  CS
`ifdef SPI_MASTER_ECHO_CHECK_EN
   ,
   output logic                  ECHO_ERR
`endif
);

   localparam int unsigned   HPW     = $clog2(2 * DATA_WIDTH);
   localparam logic [HPW-1:0] LAST_HP = HPW'(2 * DATA_WIDTH - 1);

   spi_state_e            state_q;
   logic [HPW-1:0]        hp_q;
   logic [DATA_WIDTH-1:0] tx_sr_q;
   logic [DATA_WIDTH-1:0] rx_sr_q;
   logic [DATA_WIDTH-1:0] rx_data_q;
   logic                  rx_valid_q;
   logic                  ready_q;
   logic                  sclk_q;
   logic                  mosi_q;
   logic                  cs_q;
   logic                  tick;

`ifdef SPI_MASTER_ECHO_CHECK_EN
   logic [DATA_WIDTH-1:0] tx_word_q;
   logic                  echo_err_q;
   assign ECHO_ERR = echo_err_q;
`endif

   spi_clk_div #(
      .CLK_DIV (CLK_DIV)
   ) u_clk_div (
      .clk_i  (CLK),
      .rst_i  (RST),
      .en_i   (state_q != IDLE),
      .tick_o (tick)
   );

   assign TX_READY = ready_q;
   assign RX_DATA  = rx_data_q;
   assign RX_VALID = rx_valid_q;
   assign SCLK     = sclk_q;
   assign MOSI     = mosi_q;
   assign CS       = cs_q;

   always_ff @(posedge CLK) begin
      rx_valid_q <= 1'b0;
`ifdef SPI_MASTER_ECHO_CHECK_EN
      echo_err_q <= 1'b0;
`endif
      if (RST) begin
         state_q   <= IDLE;
         hp_q      <= '0;
         tx_sr_q   <= '0;
         rx_sr_q   <= '0;
         rx_data_q <= '0;
         ready_q   <= 1'b1;
         sclk_q    <= 1'b0;
         mosi_q    <= 1'b0;
         cs_q      <= 1'b1;
`ifdef SPI_MASTER_ECHO_CHECK_EN
         tx_word_q <= '0;
`endif
      end else begin
         case (state_q)
            IDLE: begin
               if (TX_VALID) begin
                  // MSB goes straight onto MOSI; tx_sr_q holds the remaining bits
                  state_q <= SETUP;
                  cs_q    <= 1'b0;
                  ready_q <= 1'b0;
                  mosi_q  <= TX_DATA[DATA_WIDTH-1];
                  tx_sr_q <= {TX_DATA[DATA_WIDTH-2:0], 1'b0};
                  hp_q    <= '0;
`ifdef SPI_MASTER_ECHO_CHECK_EN
                  tx_word_q <= TX_DATA;
`endif
               end
            end
            SETUP: begin
               if (tick) state_q <= XFER;
            end
            XFER: begin
               if (tick) begin
                  sclk_q <= ~sclk_q;
                  if (!sclk_q) begin
                     rx_sr_q <= {rx_sr_q[DATA_WIDTH-2:0], MISO};
                  end else if (hp_q != LAST_HP) begin
                     // last falling edge leaves the LSB on MOSI through HOLD
                     mosi_q  <= tx_sr_q[DATA_WIDTH-1];
                     tx_sr_q <= {tx_sr_q[DATA_WIDTH-2:0], 1'b0};
                  end
                  if (hp_q == LAST_HP) begin
                     state_q <= HOLD;
                     hp_q    <= '0;
                  end else begin
                     hp_q <= hp_q + HPW'(1);
                  end
               end
            end
            HOLD: begin
               if (tick) begin
                  state_q    <= IDLE;
                  cs_q       <= 1'b1;
                  mosi_q     <= 1'b0;
                  ready_q    <= 1'b1;
                  rx_valid_q <= 1'b1;
                  rx_data_q  <= rx_sr_q;
`ifdef SPI_MASTER_ECHO_CHECK_EN
                  echo_err_q <= (rx_sr_q != tx_word_q);
`endif
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_spi_master.sv
// tb_spi_master: directed self-checking bench for spi_master.
// Instance A uses CLK_DIV=2, instance B uses CLK_DIV=1 (loopback only).
module tb_spi_master;

   logic       CLK = 1'b0;
   logic       RST;
   logic [7:0] TX_DATA,  TX_DATA_B;
   logic       TX_VALID, TX_VALID_B;
   logic       TX_READY, TX_READY_B;
   logic [7:0] RX_DATA,  RX_DATA_B;
   logic       RX_VALID, RX_VALID_B;
   logic       SCLK, SCLK_B, MOSI, MOSI_B, MISO, CS, CS_B;
`ifdef SPI_MASTER_ECHO_CHECK_EN
   logic       ECHO_ERR, ECHO_ERR_B;
`endif

   int vectors = 0;
   int errors  = 0;

   // MISO source for A: 0 loopback, 1 pattern, 2 forced low
   int         miso_mode = 0;
   logic [7:0] pat = 8'h00;
   logic       pat_bit;

   // monitor counters, sampled 2 time units after each rising CLK edge
   int   rises = 0, cs_low = 0, rxv = 0, mosi0 = 0;
   int   rises_b = 0, cs_low_b = 0, cyc = 0, t1_b = 0, t2_b = 0;
   logic sclk_prev = 1'b0, sclk_prev_b = 1'b0;

   always #5 CLK = ~CLK;

   assign pat_bit = (rises < 8) ? pat[3'(7 - rises)] : 1'b0;
   assign MISO    = (miso_mode == 0) ? MOSI : (miso_mode == 1) ? pat_bit : 1'b0;

   spi_master #(.CLK_DIV(2), .DATA_WIDTH(8)) dut_a (
      .CLK(CLK), .RST(RST), .TX_DATA(TX_DATA), .TX_VALID(TX_VALID),
      .TX_READY(TX_READY), .RX_DATA(RX_DATA), .RX_VALID(RX_VALID),
      .SCLK(SCLK), .MOSI(MOSI), .MISO(MISO), .CS(CS)
`ifdef SPI_MASTER_ECHO_CHECK_EN
      , .ECHO_ERR(ECHO_ERR)
`endif
   );

   spi_master #(.CLK_DIV(1), .DATA_WIDTH(8)) dut_b (
      .CLK(CLK), .RST(RST), .TX_DATA(TX_DATA_B), .TX_VALID(TX_VALID_B),
      .TX_READY(TX_READY_B), .RX_DATA(RX_DATA_B), .RX_VALID(RX_VALID_B),
      .SCLK(SCLK_B), .MOSI(MOSI_B), .MISO(MOSI_B), .CS(CS_B)
`ifdef SPI_MASTER_ECHO_CHECK_EN
      , .ECHO_ERR(ECHO_ERR_B)
`endif
   );

   always begin
      @(posedge CLK);
      #2;
      cyc = cyc + 1;
      if (SCLK && !sclk_prev) rises = rises + 1;
      if (!CS) cs_low = cs_low + 1;
      if (!CS && !MOSI) mosi0 = mosi0 + 1;
      if (RX_VALID) rxv = rxv + 1;
      sclk_prev = SCLK;
      if (SCLK_B && !sclk_prev_b) begin
         rises_b = rises_b + 1;
         if (rises_b == 1) t1_b = cyc;
         if (rises_b == 2) t2_b = cyc;
      end
      if (!CS_B) cs_low_b = cs_low_b + 1;
      sclk_prev_b = SCLK_B;
   end

   task automatic clear_mon();
      rises = 0; cs_low = 0; rxv = 0; mosi0 = 0;
      rises_b = 0; cs_low_b = 0; t1_b = 0; t2_b = 0;
   endtask

   // accept a word on A; returns at the negedge of the cycle after accept
   task automatic start_a(input logic [7:0] d);
      @(negedge CLK);
      TX_DATA  = d;
      TX_VALID = 1'b1;
      @(negedge CLK);
      TX_VALID = 1'b0;
   endtask

   task automatic wait_rxv(input int budget);
      bit ok = 0;
      for (int i = 0; i < budget; i++) begin
         @(negedge CLK);
         if (RX_VALID) begin ok = 1; break; end
      end
      vectors++;
      if (!ok) begin errors++; $display("FAIL rx_valid_wait got=0 exp=1"); end
   endtask

   task automatic test_reset();
      RST = 1'b1;
      repeat (3) @(negedge CLK);
      vectors++; if (CS !== 1'b1)       begin errors++; $display("FAIL rst_cs got=%b exp=1", CS); end
      vectors++; if (SCLK !== 1'b0)     begin errors++; $display("FAIL rst_sclk got=%b exp=0", SCLK); end
      vectors++; if (MOSI !== 1'b0)     begin errors++; $display("FAIL rst_mosi got=%b exp=0", MOSI); end
      vectors++; if (RX_DATA !== 8'h00) begin errors++; $display("FAIL rst_rxdata got=%h exp=00", RX_DATA); end
      vectors++; if (RX_VALID !== 1'b0) begin errors++; $display("FAIL rst_rxvalid got=%b exp=0", RX_VALID); end
      vectors++; if (TX_READY !== 1'b1) begin errors++; $display("FAIL rst_txready got=%b exp=1", TX_READY); end
      vectors++; if (CS_B !== 1'b1)     begin errors++; $display("FAIL rst_cs_b got=%b exp=1", CS_B); end
      RST = 1'b0;
      @(negedge CLK);
   endtask

   task automatic test_loopback();
      miso_mode = 0;
      clear_mon();
      start_a(8'hA5);
      vectors++; if (CS !== 1'b0)       begin errors++; $display("FAIL acc_cs got=%b exp=0", CS); end
      vectors++; if (MOSI !== 1'b1)     begin errors++; $display("FAIL acc_mosi got=%b exp=1", MOSI); end
      vectors++; if (SCLK !== 1'b0)     begin errors++; $display("FAIL acc_sclk got=%b exp=0", SCLK); end
      vectors++; if (TX_READY !== 1'b0) begin errors++; $display("FAIL acc_txready got=%b exp=0", TX_READY); end
      wait_rxv(200);
      vectors++; if (RX_DATA !== 8'hA5) begin errors++; $display("FAIL lb_rxdata got=%h exp=a5", RX_DATA); end
      vectors++; if (CS !== 1'b1)       begin errors++; $display("FAIL done_cs got=%b exp=1", CS); end
      vectors++; if (MOSI !== 1'b0)     begin errors++; $display("FAIL done_mosi got=%b exp=0", MOSI); end
      vectors++; if (TX_READY !== 1'b1) begin errors++; $display("FAIL done_txready got=%b exp=1", TX_READY); end
      repeat (4) @(negedge CLK);
      vectors++; if (rises !== 8)   begin errors++; $display("FAIL lb_sclk_rises got=%0d exp=8", rises); end
      vectors++; if (cs_low !== 36) begin errors++; $display("FAIL lb_cs_low got=%0d exp=36", cs_low); end
      vectors++; if (rxv !== 1)     begin errors++; $display("FAIL lb_rxvalid_count got=%0d exp=1", rxv); end
   endtask

   task automatic test_miso_pattern();
      clear_mon();
      pat = 8'h3C;
      miso_mode = 1;
      start_a(8'hFF);
      wait_rxv(200);
      vectors++; if (RX_DATA !== 8'h3C) begin errors++; $display("FAIL pat_rxdata got=%h exp=3c", RX_DATA); end
      vectors++; if (mosi0 !== 0) begin errors++; $display("FAIL pat_mosi_zero_cycles got=%0d exp=0", mosi0); end
      repeat (2) @(negedge CLK);
      miso_mode = 0;
   endtask

   task automatic test_back_to_back();
      miso_mode = 0;
      clear_mon();
      @(negedge CLK);
      TX_DATA  = 8'h01;
      TX_VALID = 1'b1;
      @(negedge CLK);
      TX_DATA  = 8'h80;   // mid-transfer change must not affect the first word
      vectors++; if (TX_READY !== 1'b0) begin errors++; $display("FAIL b2b_txready got=%b exp=0", TX_READY); end
      wait_rxv(200);
      vectors++; if (RX_DATA !== 8'h01) begin errors++; $display("FAIL b2b_first got=%h exp=01", RX_DATA); end
      vectors++; if (CS !== 1'b1)       begin errors++; $display("FAIL b2b_gap_cs got=%b exp=1", CS); end
      @(negedge CLK);
      TX_VALID = 1'b0;
      vectors++; if (CS !== 1'b0) begin errors++; $display("FAIL b2b_restart_cs got=%b exp=0", CS); end
      wait_rxv(200);
      vectors++; if (RX_DATA !== 8'h80) begin errors++; $display("FAIL b2b_second got=%h exp=80", RX_DATA); end
      repeat (60) @(negedge CLK);
      vectors++; if (rxv !== 2) begin errors++; $display("FAIL b2b_rxvalid_count got=%0d exp=2", rxv); end
   endtask

   task automatic test_reset_mid();
      bit ok = 0;
      miso_mode = 0;
      clear_mon();
      start_a(8'hF0);
      for (int i = 0; i < 200; i++) begin
         if (rises == 5) begin ok = 1; break; end
         @(negedge CLK);
      end
      vectors++; if (!ok) begin errors++; $display("FAIL rstmid_wait got=%0d exp=5", rises); end
      RST      = 1'b1;
      TX_VALID = 1'b1;
      TX_DATA  = 8'h77;
      @(negedge CLK);
      vectors++; if (CS !== 1'b1)       begin errors++; $display("FAIL rstmid_cs got=%b exp=1", CS); end
      vectors++; if (SCLK !== 1'b0)     begin errors++; $display("FAIL rstmid_sclk got=%b exp=0", SCLK); end
      vectors++; if (TX_READY !== 1'b1) begin errors++; $display("FAIL rstmid_txready got=%b exp=1", TX_READY); end
      vectors++; if (RX_VALID !== 1'b0) begin errors++; $display("FAIL rstmid_rxvalid got=%b exp=0", RX_VALID); end
      RST      = 1'b0;
      TX_VALID = 1'b0;
      repeat (60) @(negedge CLK);
      vectors++; if (rxv !== 0)   begin errors++; $display("FAIL rstmid_rxvalid_count got=%0d exp=0", rxv); end
      vectors++; if (CS !== 1'b1) begin errors++; $display("FAIL rstmid_idle_cs got=%b exp=1", CS); end
   endtask

   task automatic test_clkdiv1();
      bit ok = 0;
      clear_mon();
      @(negedge CLK);
      TX_DATA_B  = 8'hC3;
      TX_VALID_B = 1'b1;
      @(negedge CLK);
      TX_VALID_B = 1'b0;
      for (int i = 0; i < 100; i++) begin
         @(negedge CLK);
         if (RX_VALID_B) begin ok = 1; break; end
      end
      vectors++; if (!ok) begin errors++; $display("FAIL div1_wait got=0 exp=1"); end
      vectors++; if (RX_DATA_B !== 8'hC3) begin errors++; $display("FAIL div1_rxdata got=%h exp=c3", RX_DATA_B); end
      @(negedge CLK);
      vectors++; if (t2_b - t1_b !== 2) begin errors++; $display("FAIL div1_sclk_period got=%0d exp=2", t2_b - t1_b); end
      vectors++; if (rises_b !== 8)     begin errors++; $display("FAIL div1_rises got=%0d exp=8", rises_b); end
      vectors++; if (cs_low_b !== 18)   begin errors++; $display("FAIL div1_cs_low got=%0d exp=18", cs_low_b); end
   endtask

`ifdef SPI_MASTER_ECHO_CHECK_EN
   task automatic test_echo();
      miso_mode = 2;
      start_a(8'h55);
      wait_rxv(200);
      vectors++; if (RX_DATA !== 8'h00) begin errors++; $display("FAIL echo_rxdata got=%h exp=00", RX_DATA); end
      vectors++; if (ECHO_ERR !== 1'b1) begin errors++; $display("FAIL echo_err_set got=%b exp=1", ECHO_ERR); end
      @(negedge CLK);
      vectors++; if (ECHO_ERR !== 1'b0) begin errors++; $display("FAIL echo_err_pulse got=%b exp=0", ECHO_ERR); end
      miso_mode = 0;
      start_a(8'h55);
      wait_rxv(200);
      vectors++; if (RX_DATA !== 8'h55) begin errors++; $display("FAIL echo_lb_rxdata got=%h exp=55", RX_DATA); end
      vectors++; if (ECHO_ERR !== 1'b0) begin errors++; $display("FAIL echo_err_clear got=%b exp=0", ECHO_ERR); end
   endtask
`endif

   initial begin
      RST        = 1'b1;
      TX_DATA    = 8'h00;
      TX_VALID   = 1'b0;
      TX_DATA_B  = 8'h00;
      TX_VALID_B = 1'b0;
      test_reset();
      test_loopback();
      test_miso_pattern();
      test_back_to_back();
      test_reset_mid();
      test_clkdiv1();
`ifdef SPI_MASTER_ECHO_CHECK_EN
      test_echo();
`endif
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
